// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe_stage_bank register chain.
package pipe_pkg;

   localparam int unsigned PIPE_MAX_STAGES = 8;

   typedef struct packed {
      logic flush;
      logic hold;
      logic bubble;
   } stage_ctrl_t;

   // hold[k] = OR of stall[k..MAX-1]; callers zero-pad unused upper stages.
   function automatic logic [PIPE_MAX_STAGES-1:0] hold_vec(
      input logic [PIPE_MAX_STAGES-1:0] stall
   );
      logic [PIPE_MAX_STAGES-1:0] w_hold;
      logic                       w_acc;
      w_acc = 1'b0;
      for (int k = PIPE_MAX_STAGES - 1; k >= 0; k--) begin
         w_acc     = w_acc | stall[k];
         w_hold[k] = w_acc;
      end
      return w_hold;
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One valid+payload pipeline register: flush > hold > bubble > advance.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  stage_ctrl_t      i_ctrl,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_ctrl.flush || (i_ctrl.bubble && !i_ctrl.hold)) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (!i_ctrl.hold) begin
         r_valid <= i_valid;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_bank.sv
// Bank of STAGES pipeline registers with stall propagation, bubbles and flush.
// Optional perf counters (stall_cycles, bubble_count) under PIPE_STAGE_PERF_EN.
module pipe_stage_bank
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      in_ready,
   input  logic [STAGES-1:0]         stall_i,
   input  logic [STAGES-1:0]         flush_i,
   output logic [STAGES-1:0]         stage_valid,
   output logic [STAGES*WIDTH-1:0]   stage_data,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]          stall_cycles,
   output logic [CNT_W-1:0]          bubble_count
`endif
);

   logic [PIPE_MAX_STAGES-1:0] w_stall_ext;
   logic [STAGES-1:0]          w_hold;
   logic [STAGES-1:0]          w_bubble;
   stage_ctrl_t                w_ctrl [STAGES];

   always_comb begin
      w_stall_ext               = '0;
      w_stall_ext[STAGES-1:0]   = stall_i;
      w_hold                    = STAGES'(hold_vec(w_stall_ext));
      // A bubble enters stage k when its upstream neighbour is frozen but it is not.
      w_bubble                  = '0;
      for (int k = 1; k < STAGES; k++) begin
         w_bubble[k] = w_hold[k-1] & ~w_hold[k];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_ctrl[k].flush  = flush_i[k];
         w_ctrl[k].hold   = w_hold[k];
         w_ctrl[k].bubble = w_bubble[k];
      end
   end

   assign in_ready = ~w_hold[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             w_prev_valid;
      logic [WIDTH-1:0] w_prev_data;

      if (k == 0) begin : g_head
         assign w_prev_valid = in_valid;
         assign w_prev_data  = in_data;
      end else begin : g_link
         assign w_prev_valid = stage_valid[k-1];
         assign w_prev_data  = stage_data[(k-1)*WIDTH +: WIDTH];
      end

      pipe_stage_reg #(
         .WIDTH (WIDTH)
      ) u_reg (
         .clk     (clk),
         .reset   (reset),
         .i_ctrl  (w_ctrl[k]),
         .i_valid (w_prev_valid),
         .i_data  (w_prev_data),
         .o_valid (stage_valid[k]),
         .o_data  (stage_data[k*WIDTH +: WIDTH])
      );
   end

   assign out_valid = stage_valid[STAGES-1];
   assign out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;
   logic             w_bubble_evt;

   // Flush outranks bubble insertion, so a flushed stage does not count.
   assign w_bubble_evt = |(w_bubble & ~flush_i);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_hold[0] && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_bubble_evt && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         end
      end
   end

   assign stall_cycles = r_stall_cnt;
   assign bubble_count = r_bubble_cnt;
`else
   logic [CNT_W-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Randomised and directed bench for pipe_stage_bank against a stage-array model.
// Checks perf counters too when built with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_bank;

   localparam int W    = 64;
   localparam int S    = 3;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic           in_ready;
   logic [S-1:0]   stall_i = '0;
   logic [S-1:0]   flush_i = '0;
   logic [S-1:0]   stage_valid;
   logic [S*W-1:0] stage_data;
   logic           out_valid;
   logic [W-1:0]   out_data;
`ifdef PIPE_STAGE_PERF_EN
   logic [CW-1:0]  stall_cycles;
   logic [CW-1:0]  bubble_count;
`endif

   always #5 clk = ~clk;

   pipe_stage_bank #(
      .WIDTH  (W),
      .STAGES (S),
      .CNT_W  (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .stage_valid  (stage_valid),
      .stage_data   (stage_data),
      .out_valid    (out_valid),
      .out_data     (out_data)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .bubble_count (bubble_count)
`endif
   );

   // Reference model: contents of each stage plus counters.
   logic         m_valid [S];
   logic [W-1:0] m_data  [S];
   int           m_stall_cnt;
   int           m_bubble_cnt;
   int           n_checks = 0;
   int           n_fail   = 0;

   function automatic void model_clear();
      for (int k = 0; k < S; k++) begin
         m_valid[k] = 1'b0;
         m_data[k]  = '0;
      end
      m_stall_cnt  = 0;
      m_bubble_cnt = 0;
   endfunction

   // A stage is frozen when it or anything downstream requests a stall.
   function automatic bit frozen(int k);
      for (int j = k; j < S; j++) if (stall_i[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [S-1:0] exp_valid();
      logic [S-1:0] r;
      for (int k = 0; k < S; k++) r[k] = m_valid[k];
      return r;
   endfunction

   function automatic logic [S*W-1:0] exp_data();
      logic [S*W-1:0] r;
      for (int k = 0; k < S; k++) r[k*W +: W] = m_data[k];
      return r;
   endfunction

   // Apply one clock edge to the model from the inputs now driven, then let the DUT clock.
   task automatic step();
      logic         nv [S];
      logic [W-1:0] nd [S];
      bit           bub = 1'b0;
      for (int k = 0; k < S; k++) begin
         if (flush_i[k]) begin
            nv[k] = 1'b0; nd[k] = '0;
         end else if (frozen(k)) begin
            nv[k] = m_valid[k]; nd[k] = m_data[k];
         end else if (k > 0 && frozen(k - 1)) begin
            nv[k] = 1'b0; nd[k] = '0; bub = 1'b1;
         end else if (k == 0) begin
            nv[k] = in_valid; nd[k] = in_data;
         end else begin
            nv[k] = m_valid[k-1]; nd[k] = m_data[k-1];
         end
      end
      if (frozen(0) && m_stall_cnt < CMAX) m_stall_cnt++;
      if (bub && m_bubble_cnt < CMAX) m_bubble_cnt++;
      @(posedge clk);
      for (int k = 0; k < S; k++) begin
         m_valid[k] = nv[k];
         m_data[k]  = nd[k];
      end
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_data = '0; stall_i = '0; flush_i = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      model_clear();
      #3;
      n_checks++;
      if (stage_valid !== '0) begin
         n_fail++; $display("FAIL reset_valid: got %b expected 0", stage_valid);
      end
      n_checks++;
      if (stage_data !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0", stage_data);
      end
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_hs: in_ready %b out_valid %b expected 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_stream();
      logic [W-1:0] vals [4];
      int           highs = 0;
      vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33; vals[3] = 64'h44;
      for (int c = 0; c < 8; c++) begin
         in_valid = (c < 4);
         in_data  = (c < 4) ? vals[c] : '0;
         step();
         if (out_valid === 1'b1) highs++;
         n_checks++;
         if (out_valid !== (c >= 2 && c <= 5)) begin
            n_fail++; $display("FAIL stream_valid c%0d: got %b expected %b", c, out_valid, (c >= 2 && c <= 5));
         end
         if (c >= 2 && c <= 5) begin
            n_checks++;
            if (out_data !== vals[c-2]) begin
               n_fail++; $display("FAIL stream_data c%0d: got %h expected %h", c, out_data, vals[c-2]);
            end
         end
      end
      n_checks++;
      if (highs != 4) begin
         n_fail++; $display("FAIL stream_count: got %0d cycles expected 4", highs);
      end
      idle_inputs();
   endtask

   task automatic test_mid_stall();
      in_valid = 1'b1; in_data = 64'hA1; step();
      in_data = 64'hB2; step();
      for (int c = 0; c < 2; c++) begin
         stall_i = 3'b010; in_data = 64'hC3;
         #1;
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_ready c%0d: got %b expected 0", c, in_ready);
         end
         step();
         n_checks++;
         if (stage_data[W +: W] !== 64'hA1 || stage_data[0 +: W] !== 64'hB2
             || stage_valid !== 3'b011) begin
            n_fail++; $display("FAIL stall_freeze c%0d: got valid %b s1 %h s0 %h expected 011 a1 b2",
                               c, stage_valid, stage_data[W +: W], stage_data[0 +: W]);
         end
      end
      stall_i = '0; in_valid = 1'b0;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hA1) begin
         n_fail++; $display("FAIL stall_release: got %b %h expected 1 a1", out_valid, out_data);
      end
      step(); step();
      idle_inputs();
   endtask

   task automatic test_flush_over_stall();
      in_valid = 1'b1;
      in_data = 64'hD1; step();
      in_data = 64'hD2; step();
      in_data = 64'hD3; step();
      stall_i = 3'b010; flush_i = 3'b010; in_data = 64'hE4;
      step();
      n_checks++;
      if (stage_valid !== 3'b001 || stage_data[0 +: W] !== 64'hD3) begin
         n_fail++; $display("FAIL flush_stall: got valid %b s0 %h expected 001 d3",
                            stage_valid, stage_data[0 +: W]);
      end
      n_checks++;
      if (stage_data !== exp_data()) begin
         n_fail++; $display("FAIL flush_stall_model: got %h expected %h", stage_data, exp_data());
      end
      idle_inputs();
      step(); step(); step();
   endtask

   task automatic test_full_flush();
      in_valid = 1'b1;
      in_data = 64'hF1; step();
      in_data = 64'hF2; step();
      in_data = 64'hF3; step();
      n_checks++;
      if (stage_valid !== 3'b111) begin
         n_fail++; $display("FAIL fill3: got %b expected 111", stage_valid);
      end
      flush_i = 3'b111; in_data = 64'hF4;
      step();
      n_checks++;
      if (stage_valid !== 3'b000 || out_valid !== 1'b0 || stage_data !== '0) begin
         n_fail++; $display("FAIL full_flush: got %b out %b data %h expected 000 0 0",
                            stage_valid, out_valid, stage_data);
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1;
      in_data = 64'h51; step();
      in_data = 64'h52; step();
      in_data = 64'h53; step();
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      n_checks++;
      if (stage_valid !== '0 || out_data !== '0 || stage_data !== '0) begin
         n_fail++; $display("FAIL async_reset: got valid %b out %h expected 0 0", stage_valid, out_data);
      end
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1; in_data = 64'h77;
      step();
      in_valid = 1'b0; in_data = '0;
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_early: got %b expected 0", out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'h77) begin
         n_fail++; $display("FAIL post_reset_lat: got %b %h expected 1 77", out_valid, out_data);
      end
      step();
      idle_inputs();
   endtask

`ifdef PIPE_STAGE_PERF_EN
   task automatic test_perf_saturate();
      test_reset();
      stall_i = 3'b100;
      for (int c = 0; c < 20; c++) begin
         in_valid = 1'b1; in_data = {$urandom, $urandom};
         step();
      end
      n_checks++;
      if (stall_cycles !== CW'(CMAX) || bubble_count !== '0) begin
         n_fail++; $display("FAIL perf_sat: got stall %h bubble %h expected f 0", stall_cycles, bubble_count);
      end
      idle_inputs();
      test_reset();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < S; k++) begin
            stall_i[k] = ($urandom_range(0, 5) == 0);
            flush_i[k] = ($urandom_range(0, 11) == 0);
         end
         in_valid = $urandom_range(0, 1);
         in_data  = {$urandom, $urandom};
         #1;
         n_checks++;
         if (in_ready !== !frozen(0)) begin
            n_fail++; $display("FAIL rand_ready c%0d: got %b expected %b", c, in_ready, !frozen(0));
         end
         step();
         n_checks++;
         if (stage_valid !== exp_valid()) begin
            n_fail++; $display("FAIL rand_valid c%0d: got %b expected %b", c, stage_valid, exp_valid());
         end
         n_checks++;
         if (stage_data !== exp_data()) begin
            n_fail++; $display("FAIL rand_data c%0d: got %h expected %h", c, stage_data, exp_data());
         end
         n_checks++;
         if (out_valid !== m_valid[S-1] || out_data !== m_data[S-1]) begin
            n_fail++; $display("FAIL rand_out c%0d: got %b %h expected %b %h",
                               c, out_valid, out_data, m_valid[S-1], m_data[S-1]);
         end
`ifdef PIPE_STAGE_PERF_EN
         n_checks++;
         if (stall_cycles !== CW'(m_stall_cnt) || bubble_count !== CW'(m_bubble_cnt)) begin
            n_fail++; $display("FAIL rand_perf c%0d: got %0d %0d expected %0d %0d",
                               c, stall_cycles, bubble_count, m_stall_cnt, m_bubble_cnt);
         end
`endif
      end
      idle_inputs();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_stream();
      test_mid_stall();
      test_flush_over_stall();
      test_full_flush();
      test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
      test_perf_saturate();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
